// File: rtl/branch_predict_unit.sv
// branch_predict_unit: ID-stage branch resolver with a direct-mapped BTB, 2-bit counters,
// a registered flush/redirect on mispredict, and a saturating mispredict counter.
module branch_predict_unit #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_valid,
    input  logic [DATA_W-1:0] f_pc,
    output logic              p_hit,
    output logic              p_taken,
    output logic [DATA_W-1:0] p_target,
    input  logic              r_valid,
    input  logic [3:0]        r_op,
    input  logic [DATA_W-1:0] r_rd1,
    input  logic [DATA_W-1:0] r_r0r,
    input  logic [DATA_W-1:0] r_pc,
    input  logic [DATA_W-1:0] r_offset,
    input  logic              r_pred_taken,
    input  logic [DATA_W-1:0] r_pred_target,
    output logic              flush,
    output logic [DATA_W-1:0] redirect_pc,
    output logic              br_taken,
    output logic [CNT_W-1:0]  mispred_cnt
);
    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = DATA_W - IDX_W - 1;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [TAG_W-1:0]   tag_d [ENTRIES];
    logic [DATA_W-1:0]  tgt_q [ENTRIES];
    logic [DATA_W-1:0]  tgt_d [ENTRIES];
    logic [1:0]         ctr_q [ENTRIES];
    logic [1:0]         ctr_d [ENTRIES];

    logic              p_hit_q, p_hit_d, p_taken_q, p_taken_d;
    logic [DATA_W-1:0] p_target_q, p_target_d;
    logic              flush_q, flush_d, br_taken_q, br_taken_d;
    logic [DATA_W-1:0] redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0]  mispred_cnt_q, mispred_cnt_d;

    logic [IDX_W-1:0]  f_idx, r_idx;
    logic [TAG_W-1:0]  f_tag, r_tag;
    logic              f_hit, r_hit, is_br, taken, mispred;
    logic [DATA_W-1:0] actual, fall;

    assign f_idx   = f_pc[IDX_W:1];
    assign f_tag   = f_pc[DATA_W-1:IDX_W+1];
    assign r_idx   = r_pc[IDX_W:1];
    assign r_tag   = r_pc[DATA_W-1:IDX_W+1];
    assign f_hit   = f_valid && valid_q[f_idx] && tag_q[f_idx] == f_tag;
    assign r_hit   = valid_q[r_idx] && tag_q[r_idx] == r_tag;
    assign is_br   = r_op == 4'b0100 || r_op == 4'b0101 || r_op == 4'b0110;
    assign actual  = r_pc + r_offset;
    assign fall    = r_pc + DATA_W'(2);
    assign taken   = r_op == 4'b0100 ? $signed(r_rd1) < $signed(r_r0r) :
                     r_op == 4'b0101 ? $signed(r_rd1) > $signed(r_r0r) :
                     r_op == 4'b0110 ? r_rd1 == r_r0r : 1'b0;
    // A non-branch predicted taken falls out of the first term and redirects to fallthrough.
    assign mispred = r_valid && (taken != r_pred_taken || (taken && r_pred_target != actual));

    always_comb begin
        p_hit_d       = f_hit;
        p_taken_d     = f_hit && ctr_q[f_idx][1];
        p_target_d    = f_hit ? tgt_q[f_idx] : '0;
        flush_d       = mispred;
        redirect_pc_d = mispred ? (taken ? actual : fall) : redirect_pc_q;
        br_taken_d    = r_valid ? taken : br_taken_q;
        mispred_cnt_d = mispred && !(&mispred_cnt_q) ? mispred_cnt_q + CNT_W'(1) : mispred_cnt_q;
    end

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        ctr_d   = ctr_q;
        if (r_valid && is_br) begin
            if (r_hit) begin
                ctr_d[r_idx] = taken ? (ctr_q[r_idx] == 2'b11 ? 2'b11 : ctr_q[r_idx] + 2'd1)
                                     : (ctr_q[r_idx] == 2'b00 ? 2'b00 : ctr_q[r_idx] - 2'd1);
                tgt_d[r_idx] = actual;
            end else if (taken) begin
                valid_d[r_idx] = 1'b1;
                tag_d[r_idx]   = r_tag;
                tgt_d[r_idx]   = actual;
                ctr_d[r_idx]   = 2'b10;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q       <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                ctr_q[i] <= 2'b01;
            end
            p_hit_q       <= 1'b0;
            p_taken_q     <= 1'b0;
            p_target_q    <= '0;
            flush_q       <= 1'b0;
            redirect_pc_q <= '0;
            br_taken_q    <= 1'b0;
            mispred_cnt_q <= '0;
        end else begin
            valid_q       <= valid_d;
            tag_q         <= tag_d;
            tgt_q         <= tgt_d;
            ctr_q         <= ctr_d;
            p_hit_q       <= p_hit_d;
            p_taken_q     <= p_taken_d;
            p_target_q    <= p_target_d;
            flush_q       <= flush_d;
            redirect_pc_q <= redirect_pc_d;
            br_taken_q    <= br_taken_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign p_hit       = p_hit_q;
    assign p_taken     = p_taken_q;
    assign p_target    = p_target_q;
    assign flush       = flush_q;
    assign redirect_pc = redirect_pc_q;
    assign br_taken    = br_taken_q;
    assign mispred_cnt = mispred_cnt_q;
endmodule
